// File: rtl/apb_req_arbiter.sv
// Round-robin arbiter that shares one APB master among NREQ requesters,
// sequencing grant, transfer monitoring, watchdog abort and acknowledge.
module apb_req_arbiter #(
    parameter int NREQ    = 4,
    parameter int AW      = 4,
    parameter int DW      = 16,
    parameter int TIMEOUT = 16
) (
    input  logic               pclk,
    input  logic               preset_n,
    input  logic [NREQ-1:0]    req,
    input  logic [NREQ*AW-1:0] req_addr,
    input  logic [NREQ*DW-1:0] req_wdata,
    input  logic [NREQ-1:0]    req_write,
    output logic [NREQ-1:0]    gnt,
    output logic [NREQ-1:0]    ack,
    output logic [DW-1:0]      rdata,
    output logic               err,
    output logic               busy,
    output logic               m_start,
    output logic [AW-1:0]      m_addr,
    output logic [DW-1:0]      m_wdata,
    output logic               m_write,
    input  logic               mon_penable,
    input  logic               mon_pready,
    input  logic [DW-1:0]      mon_prdata
);

    localparam int IW = (NREQ > 1) ? $clog2(NREQ) : 1;
    localparam int CW = $clog2(TIMEOUT);
    localparam logic [CW-1:0] WCNT_LAST = CW'(TIMEOUT - 1);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_BUSY = 2'd1,
        S_DONE = 2'd2
    } state_t;

    // Requester handshake: req is a level held until its one-cycle ack;
    // req_* fields are captured only at grant, and dropping req while
    // granted does not cancel the transfer.

    state_t          state_q;
    logic [IW-1:0]   ptr_q;
    logic [IW-1:0]   win_q;
    logic [IW-1:0]   win_d;
    logic [CW-1:0]   wcnt_q;
    logic [NREQ-1:0] gnt_q;
    logic [NREQ-1:0] ack_q;
    logic [DW-1:0]   rdata_q;
    logic            err_q;
    logic            m_start_q;
    logic [AW-1:0]   m_addr_q;
    logic [DW-1:0]   m_wdata_q;
    logic            m_write_q;

    logic [AW-1:0]   addr_arr  [NREQ];
    logic [DW-1:0]   wdata_arr [NREQ];

    function automatic logic [IW-1:0] rr_idx(input logic [IW-1:0] p, input int k);
        int s;
        s = int'(p) + k;
        if (s >= NREQ) s = s - NREQ;
        return IW'(s);
    endfunction

    always_comb begin
        for (int i = 0; i < NREQ; i++) begin
            addr_arr[i]  = req_addr[i*AW +: AW];
            wdata_arr[i] = req_wdata[i*DW +: DW];
        end
    end

    // First requesting index at or above ptr, wrapping at NREQ-1.
    always_comb begin
        logic found;
        found = 1'b0;
        win_d = ptr_q;
        for (int k = 0; k < NREQ; k++) begin
            if (!found && req[rr_idx(ptr_q, k)]) begin
                found = 1'b1;
                win_d = rr_idx(ptr_q, k);
            end
        end
    end

    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q   <= S_IDLE;
            ptr_q     <= '0;
            win_q     <= '0;
            wcnt_q    <= '0;
            gnt_q     <= '0;
            ack_q     <= '0;
            rdata_q   <= '0;
            err_q     <= 1'b0;
            m_start_q <= 1'b0;
            m_addr_q  <= '0;
            m_wdata_q <= '0;
            m_write_q <= 1'b0;
        end else begin
            case (state_q)
                S_IDLE: begin
                    m_start_q <= 1'b0;
                    if (|req) begin
                        state_q   <= S_BUSY;
                        win_q     <= win_d;
                        gnt_q     <= NREQ'(1) << win_d;
                        m_addr_q  <= addr_arr[win_d];
                        m_wdata_q <= wdata_arr[win_d];
                        m_write_q <= req_write[win_d];
                        m_start_q <= 1'b1;
                        wcnt_q    <= '0;
                    end
                end
                S_BUSY: begin
                    if (mon_penable && mon_pready) begin
                        rdata_q   <= m_write_q ? '0 : mon_prdata;
                        err_q     <= 1'b0;
                        ack_q     <= gnt_q;
                        m_start_q <= 1'b0;
                        state_q   <= S_DONE;
                    end else if (mon_penable) begin
                        // Completion above takes precedence over the watchdog.
                        if (wcnt_q == WCNT_LAST) begin
                            rdata_q   <= '0;
                            err_q     <= 1'b1;
                            ack_q     <= gnt_q;
                            m_start_q <= 1'b0;
                            state_q   <= S_DONE;
                        end else if (wcnt_q != '1) begin
                            wcnt_q <= wcnt_q + 1'b1;
                        end
                    end
                end
                S_DONE: begin
                    gnt_q   <= '0;
                    ack_q   <= '0;
                    rdata_q <= '0;
                    err_q   <= 1'b0;
                    ptr_q   <= (win_q == IW'(NREQ - 1)) ? '0 : win_q + 1'b1;
                    state_q <= S_IDLE;
                end
                default: begin
                    state_q   <= S_IDLE;
                    gnt_q     <= '0;
                    ack_q     <= '0;
                    m_start_q <= 1'b0;
                end
            endcase
        end
    end

    assign gnt     = gnt_q;
    assign ack     = ack_q;
    assign rdata   = rdata_q;
    assign err     = err_q;
    assign busy    = (state_q != S_IDLE);
    assign m_start = m_start_q;
    assign m_addr  = m_addr_q;
    assign m_wdata = m_wdata_q;
    assign m_write = m_write_q;

endmodule

// File: tb/tb_apb_req_arbiter.sv
// Self-checking bench for apb_req_arbiter: scenario tasks plus an ack
// scoreboard fed at grant time and drained when ack pulses.
module tb_apb_req_arbiter;

    localparam int NREQ    = 4;
    localparam int AW      = 4;
    localparam int DW      = 16;
    localparam int TIMEOUT = 16;

    logic               pclk;
    logic               preset_n;
    logic [NREQ-1:0]    req;
    logic [NREQ*AW-1:0] req_addr;
    logic [NREQ*DW-1:0] req_wdata;
    logic [NREQ-1:0]    req_write;
    logic [NREQ-1:0]    gnt;
    logic [NREQ-1:0]    ack;
    logic [DW-1:0]      rdata;
    logic               err;
    logic               busy;
    logic               m_start;
    logic [AW-1:0]      m_addr;
    logic [DW-1:0]      m_wdata;
    logic               m_write;
    logic               mon_penable;
    logic               mon_pready;
    logic [DW-1:0]      mon_prdata;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    logic [NREQ-1:0] exp_ack_q   [$];
    logic [DW-1:0]   exp_rdata_q [$];
    logic            exp_err_q   [$];

    apb_req_arbiter #(.NREQ(NREQ), .AW(AW), .DW(DW), .TIMEOUT(TIMEOUT)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .req(req), .req_addr(req_addr), .req_wdata(req_wdata), .req_write(req_write),
        .gnt(gnt), .ack(ack), .rdata(rdata), .err(err), .busy(busy),
        .m_start(m_start), .m_addr(m_addr), .m_wdata(m_wdata), .m_write(m_write),
        .mon_penable(mon_penable), .mon_pready(mon_pready), .mon_prdata(mon_prdata)
    );

    // Clock / reset
    initial pclk = 1'b0;
    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc++;

    // Scoreboard: every ack pulse is matched against the oldest expectation.
    always @(negedge pclk) begin
        if (preset_n && ack !== '0) begin
            n_checks++;
            if (exp_ack_q.size() == 0) begin
                n_fail++;
                $display("FAIL unexpected_ack: got ack=%b rdata=%h err=%b, want no ack", ack, rdata, err);
            end else begin
                logic [NREQ-1:0] e_ack;
                logic [DW-1:0]   e_rd;
                logic            e_err;
                e_ack = exp_ack_q.pop_front();
                e_rd  = exp_rdata_q.pop_front();
                e_err = exp_err_q.pop_front();
                if (ack !== e_ack || rdata !== e_rd || err !== e_err) begin
                    n_fail++;
                    $display("FAIL ack_data: got ack=%b rdata=%h err=%b, want ack=%b rdata=%h err=%b",
                             ack, rdata, err, e_ack, e_rd, e_err);
                end
            end
        end
    end

    // Driver tasks
    task automatic push_exp(input logic [NREQ-1:0] a, input logic [DW-1:0] d, input logic e);
        exp_ack_q.push_back(a);
        exp_rdata_q.push_back(d);
        exp_err_q.push_back(e);
    endtask

    task automatic do_reset();
        @(negedge pclk);
        preset_n    = 1'b0;
        req         = '0;
        mon_penable = 1'b0;
        mon_pready  = 1'b0;
        exp_ack_q.delete();
        exp_rdata_q.delete();
        exp_err_q.delete();
        @(negedge pclk);
        preset_n = 1'b1;
        @(negedge pclk);
    endtask

    task automatic wait_gnt(input int limit);
        int n;
        n = 0;
        while (gnt === '0 && n < limit) begin
            @(negedge pclk);
            n++;
        end
        n_checks++;
        if (gnt === '0) begin
            n_fail++;
            $display("FAIL gnt_wait: got gnt=%b after %0d cycles, want a grant", gnt, limit);
        end
    endtask

    // Call in the grant cycle; returns in the ack cycle.
    task automatic apb_slave(input int waits, input logic [DW-1:0] data);
        @(negedge pclk);
        mon_penable = 1'b0;
        @(negedge pclk);
        mon_penable = 1'b1;
        mon_prdata  = data;
        mon_pready  = (waits == 0);
        for (int w = 1; w <= waits; w++) begin
            @(negedge pclk);
            mon_pready = (w == waits);
        end
        @(negedge pclk);
        mon_penable = 1'b0;
        mon_pready  = 1'b0;
    endtask

    task automatic set_lane(input int i, input logic [AW-1:0] a, input logic [DW-1:0] d, input logic w);
        req_addr[i*AW +: AW]  = a;
        req_wdata[i*DW +: DW] = d;
        req_write[i]          = w;
    endtask

    // Scenarios
    task automatic test_reset();
        preset_n = 1'b0;
        @(negedge pclk);
        @(negedge pclk);
        n_checks++;
        if ({gnt, ack, rdata, err, busy, m_start, m_addr, m_wdata, m_write} !== '0) begin
            n_fail++;
            $display("FAIL reset_outputs: got gnt=%b ack=%b rdata=%h err=%b busy=%b start=%b addr=%h wdata=%h write=%b, want all 0",
                     gnt, ack, rdata, err, busy, m_start, m_addr, m_wdata, m_write);
        end
        preset_n = 1'b1;
        @(negedge pclk);
        n_checks++;
        if (busy !== 1'b0 || gnt !== '0) begin
            n_fail++;
            $display("FAIL reset_idle: got busy=%b gnt=%b, want 0 0", busy, gnt);
        end
    endtask

    task automatic test_single_read();
        int t0;
        set_lane(0, 4'h3, 16'h0000, 1'b0);
        req = 4'b0001;
        t0  = cyc;
        push_exp(4'b0001, 16'hBEEF, 1'b0);
        wait_gnt(4);
        n_checks++;
        if (gnt !== 4'b0001 || m_start !== 1'b1 || m_addr !== 4'h3 || m_write !== 1'b0) begin
            n_fail++;
            $display("FAIL read_grant: got gnt=%b start=%b addr=%h write=%b, want 0001 1 3 0", gnt, m_start, m_addr, m_write);
        end
        apb_slave(0, 16'hBEEF);
        n_checks++;
        if (cyc - t0 !== 4) begin
            n_fail++;
            $display("FAIL read_latency: got %0d cycles, want 4", cyc - t0);
        end
        n_checks++;
        if (m_start !== 1'b0 || ack !== 4'b0001) begin
            n_fail++;
            $display("FAIL read_ack_cycle: got start=%b ack=%b, want 0 0001", m_start, ack);
        end
        req = '0;
        @(negedge pclk);
        n_checks++;
        if (ack !== '0 || rdata !== '0 || err !== 1'b0 || gnt !== '0 || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL read_after_ack: got ack=%b rdata=%h err=%b gnt=%b busy=%b, want all 0", ack, rdata, err, gnt, busy);
        end
    endtask

    task automatic test_single_write();
        set_lane(2, 4'hA, 16'h1234, 1'b1);
        req = 4'b0100;
        push_exp(4'b0100, 16'h0000, 1'b0);
        wait_gnt(4);
        n_checks++;
        if (gnt !== 4'b0100 || m_addr !== 4'hA || m_wdata !== 16'h1234 || m_write !== 1'b1) begin
            n_fail++;
            $display("FAIL write_grant: got gnt=%b addr=%h wdata=%h write=%b, want 0100 a 1234 1", gnt, m_addr, m_wdata, m_write);
        end
        set_lane(2, 4'h5, 16'hFFFF, 1'b0);
        apb_slave(1, 16'hDEAD);
        n_checks++;
        if (ack !== 4'b0100 || m_addr !== 4'hA || m_wdata !== 16'h1234 || m_write !== 1'b1) begin
            n_fail++;
            $display("FAIL write_hold: got ack=%b addr=%h wdata=%h write=%b, want 0100 a 1234 1", ack, m_addr, m_wdata, m_write);
        end
        req = '0;
        @(negedge pclk);
        n_checks++;
        if (m_start !== 1'b0 || m_addr !== 4'hA || busy !== 1'b0) begin
            n_fail++;
            $display("FAIL write_idle_hold: got start=%b addr=%h busy=%b, want 0 a 0", m_start, m_addr, busy);
        end
    endtask

    task automatic test_contention();
        int order [5] = '{0, 1, 2, 3, 0};
        logic [NREQ-1:0] e;
        do_reset();
        for (int i = 0; i < NREQ; i++) set_lane(i, AW'(8 + i), 16'h0000, 1'b0);
        req = '1;
        for (int k = 0; k < 5; k++) begin
            wait_gnt(8);
            e = '0;
            e[order[k]] = 1'b1;
            n_checks++;
            if (gnt !== e || m_addr !== AW'(8 + order[k])) begin
                n_fail++;
                $display("FAIL contention_order[%0d]: got gnt=%b addr=%h, want gnt=%b addr=%h", k, gnt, m_addr, e, AW'(8 + order[k]));
            end
            push_exp(e, DW'(16'hC000 + k), 1'b0);
            apb_slave(0, DW'(16'hC000 + k));
            req[order[k]] = 1'b0;
            @(negedge pclk);
            req[order[k]] = 1'b1;
        end
        req = '0;
        @(negedge pclk);
    endtask

    task automatic test_rr_skip();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_lane(i, AW'(i), 16'h0000, 1'b0);
        req = 4'b0100;
        push_exp(4'b0100, 16'h2222, 1'b0);
        wait_gnt(4);
        apb_slave(0, 16'h2222);
        req = 4'b1001;
        @(negedge pclk);
        wait_gnt(4);
        n_checks++;
        if (gnt !== 4'b1000) begin
            n_fail++;
            $display("FAIL rr_after_2: got gnt=%b, want 1000", gnt);
        end
        push_exp(4'b1000, 16'h3333, 1'b0);
        apb_slave(0, 16'h3333);
        req = 4'b0001;
        @(negedge pclk);
        wait_gnt(4);
        n_checks++;
        if (gnt !== 4'b0001) begin
            n_fail++;
            $display("FAIL rr_wrap: got gnt=%b, want 0001", gnt);
        end
        push_exp(4'b0001, 16'h4444, 1'b0);
        apb_slave(0, 16'h4444);
        req = '0;
        @(negedge pclk);
    endtask

    task automatic test_wait_states();
        logic [DW-1:0] d;
        d = DW'($urandom_range(1, 16'hFFFF));
        set_lane(1, 4'h7, 16'h0000, 1'b0);
        req = 4'b0010;
        push_exp(4'b0010, d, 1'b0);
        wait_gnt(8);
        apb_slave(5, d);
        n_checks++;
        if (ack !== 4'b0010 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL wait_ack: got ack=%b err=%b, want 0010 0", ack, err);
        end
        req = '0;
        @(negedge pclk);
    endtask

    task automatic test_timeout();
        int c;
        set_lane(0, 4'h1, 16'h0000, 1'b0);
        req = 4'b0001;
        push_exp(4'b0001, 16'h0000, 1'b1);
        wait_gnt(8);
        @(negedge pclk);
        @(negedge pclk);
        mon_penable = 1'b1;
        mon_pready  = 1'b0;
        mon_prdata  = 16'hFFFF;
        c = 0;
        while (ack === '0 && c < TIMEOUT + 4) begin
            @(negedge pclk);
            c++;
        end
        n_checks++;
        if (c !== TIMEOUT || err !== 1'b1) begin
            n_fail++;
            $display("FAIL timeout_ack: got ack after %0d cycles err=%b, want %0d 1", c, err, TIMEOUT);
        end
        mon_penable = 1'b0;
        req = '0;
        @(negedge pclk);
        set_lane(3, 4'hE, 16'h0000, 1'b0);
        req = 4'b1000;
        push_exp(4'b1000, 16'h5A5A, 1'b0);
        wait_gnt(8);
        apb_slave(0, 16'h5A5A);
        n_checks++;
        if (ack !== 4'b1000 || err !== 1'b0) begin
            n_fail++;
            $display("FAIL after_timeout: got ack=%b err=%b, want 1000 0", ack, err);
        end
        req = '0;
        @(negedge pclk);
    endtask

    task automatic test_reset_mid_busy();
        do_reset();
        for (int i = 0; i < NREQ; i++) set_lane(i, AW'(i), 16'h0000, 1'b0);
        req = 4'b0100;
        push_exp(4'b0100, 16'h1111, 1'b0);
        wait_gnt(4);
        apb_slave(0, 16'h1111);
        req = 4'b1010;
        @(negedge pclk);
        wait_gnt(4);
        @(negedge pclk);
        mon_penable = 1'b1;
        mon_pready  = 1'b0;
        @(negedge pclk);
        preset_n = 1'b0;
        #1;
        n_checks++;
        if ({gnt, ack, rdata, err, busy, m_start, m_addr, m_wdata, m_write} !== '0) begin
            n_fail++;
            $display("FAIL reset_mid_busy: got gnt=%b ack=%b busy=%b start=%b addr=%h, want all 0", gnt, ack, busy, m_start, m_addr);
        end
        @(negedge pclk);
        mon_penable = 1'b0;
        preset_n    = 1'b1;
        push_exp(4'b0010, 16'h7777, 1'b0);
        wait_gnt(4);
        n_checks++;
        if (gnt !== 4'b0010) begin
            n_fail++;
            $display("FAIL ptr_after_reset: got gnt=%b, want 0010", gnt);
        end
        apb_slave(0, 16'h7777);
        req = '0;
        @(negedge pclk);
        @(negedge pclk);
    endtask

    initial begin
        req         = '0;
        req_addr    = '0;
        req_wdata   = '0;
        req_write   = '0;
        mon_penable = 1'b0;
        mon_pready  = 1'b0;
        mon_prdata  = '0;
        preset_n    = 1'b0;
        test_reset();
        test_single_read();
        test_single_write();
        test_wait_states();
        test_timeout();
        test_contention();
        test_rr_skip();
        test_reset_mid_busy();
        n_checks++;
        if (exp_ack_q.size() !== 0) begin
            n_fail++;
            $display("FAIL leftover_exp: got %0d pending acks, want 0", exp_ack_q.size());
        end
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
